// File: rtl/periph_shell_pkg.sv
// Shared constants for the Lycan USB peripheral shells.
// Provides the packet/address widths, the broadcast address and a FIFO pointer-width helper.
package lycan_globals;

  localparam int usb_packet_width     = 32;
  localparam int periph_address_width = 3;

  // All-ones at any width it is truncated to, so it serves every ADDR_W.
  localparam int periph_bcast_address = '1;

  // One extra pointer bit separates the full and empty states when the index bits match.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/periph_shell_if.sv
// USB-router side of a peripheral shell: TX packets in, address-tagged RX packets out.
// master = USB router, slave = peripheral shell.
interface periph_shell_if
  import lycan_globals::*;
#(
  parameter int PKT_W = usb_packet_width
);

  logic [PKT_W-1:0] tx_data;
  logic             tx_valid;
  logic             tx_full;
  logic [PKT_W-1:0] rx_data;
  logic             rx_read;
  logic             rx_empty;
  logic             rx_almost_full;
  logic             rx_full;

  modport master (
    output tx_data, tx_valid, rx_read,
    input  tx_full, rx_data, rx_empty, rx_almost_full, rx_full
  );

  modport slave (
    input  tx_data, tx_valid, rx_read,
    output tx_full, rx_data, rx_empty, rx_almost_full, rx_full
  );

endinterface

// File: rtl/periph_shell_sync_fifo.sv
// First-word fall-through synchronous FIFO with registered empty/full/almost-full flags.
// DEPTH must be a power of two; pointers carry one extra wrap bit.
module periph_sync_fifo
  import lycan_globals::*;
#(
  parameter int WIDTH = 29,
  parameter int DEPTH = 16,
  parameter int AFULL = DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = fifo_ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_nxt, rd_nxt, used_nxt;
  logic             do_wr, do_rd;

  // Full blocks a write even when a read frees a slot in the same cycle.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_nxt   = wr_ptr + PW'(do_wr);
    rd_nxt   = rd_ptr + PW'(do_rd);
    used_nxt = wr_nxt - rd_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_nxt;
      rd_ptr      <= rd_nxt;
      empty       <= (wr_nxt == rd_nxt);
      full        <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      almost_full <= (used_nxt >= PW'(AFULL));
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Head is shown only while valid so the data output reads zero when empty.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/periph_shell.sv
// Static peripheral shell: address-filtered TX FIFO, address-tagged RX FIFO and post-reset quiet period.
// Optional drop counters are built when PERIPH_SHELL_STATS_EN is defined.
module periph_shell
  import lycan_globals::*;
#(
  parameter int                PKT_W        = usb_packet_width,
  parameter int                ADDR_W       = periph_address_width,
  parameter logic [ADDR_W-1:0] ADDRESS      = '0,
  parameter bit                BCAST_EN     = 1'b1,
  parameter int                TX_DEPTH     = 16,
  parameter int                RX_DEPTH     = 16,
  parameter int                RX_AFULL     = 12,
  parameter int                READY_CYCLES = 63
) (
  input  logic                    clk,
  input  logic                    rst_n,
  periph_shell_if.slave           usb,
  output logic [PKT_W-ADDR_W-1:0] core_tx_data,
  output logic                    core_tx_empty,
  input  logic                    core_tx_rden,
  input  logic [PKT_W-ADDR_W-1:0] core_rx_data,
  input  logic                    core_rx_wren,
  output logic                    core_rx_full,
  output logic                    ready
`ifdef PERIPH_SHELL_STATS_EN
  ,
  output logic [15:0]             tx_drop_cnt,
  output logic [15:0]             rx_drop_cnt
`endif
);

  localparam int                PAY_W      = PKT_W - ADDR_W;
  localparam int                CNT_W      = $clog2(READY_CYCLES + 2);
  localparam logic [ADDR_W-1:0] BCAST_ADDR = ADDR_W'(periph_bcast_address);

  logic [ADDR_W-1:0] tx_addr;
  logic              tx_match;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ready_q;
  logic              tx_fifo_empty, tx_fifo_full, tx_afull_unused;
  logic              rx_fifo_empty, rx_fifo_full;
  logic [PAY_W-1:0]  rx_payload;

  assign tx_addr  = usb.tx_data[PKT_W-1 -: ADDR_W];
  assign tx_match = (tx_addr == ADDRESS) || (BCAST_EN && (tx_addr == BCAST_ADDR));

  // Quiet counter saturates at READY_CYCLES; ready is registered off the next count.
  always_comb begin
    cnt_nxt = cnt;
    if (cnt != CNT_W'(READY_CYCLES)) cnt_nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      ready_q <= (cnt_nxt == CNT_W'(READY_CYCLES));
    end
  end

  assign ready = ready_q;

  periph_sync_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (TX_DEPTH),
    .AFULL (TX_DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (usb.tx_valid & ready_q & tx_match),
    .wr_data     (usb.tx_data[PAY_W-1:0]),
    .rd_en       (core_tx_rden & ready_q),
    .rd_data     (core_tx_data),
    .empty       (tx_fifo_empty),
    .full        (tx_fifo_full),
    .almost_full (tx_afull_unused)
  );

  periph_sync_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (RX_DEPTH),
    .AFULL (RX_AFULL)
  ) u_rx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (core_rx_wren & ready_q),
    .wr_data     (core_rx_data),
    .rd_en       (usb.rx_read),
    .rd_data     (rx_payload),
    .empty       (rx_fifo_empty),
    .full        (rx_fifo_full),
    .almost_full (usb.rx_almost_full)
  );

  // Until the quiet period ends both producers see back-pressure and the core sees no data.
  assign usb.tx_full    = tx_fifo_full | ~ready_q;
  assign core_tx_empty  = tx_fifo_empty | ~ready_q;
  assign core_rx_full   = rx_fifo_full | ~ready_q;
  assign usb.rx_full    = rx_fifo_full;
  assign usb.rx_empty   = rx_fifo_empty;
  assign usb.rx_data    = rx_fifo_empty ? '0 : {ADDRESS, rx_payload};

`ifdef PERIPH_SHELL_STATS_EN
  // Only address-matching TX traffic counts; packets for other shells are not drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_drop_cnt <= '0;
      rx_drop_cnt <= '0;
    end else begin
      if (usb.tx_valid && tx_match && (tx_fifo_full || !ready_q) && (tx_drop_cnt != 16'hFFFF))
        tx_drop_cnt <= tx_drop_cnt + 16'd1;
      if (core_rx_wren && (rx_fifo_full || !ready_q) && (rx_drop_cnt != 16'hFFFF))
        rx_drop_cnt <= rx_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_periph_shell.sv
// Scoreboard bench for periph_shell: directed stimulus pushes expected words, a negedge monitor pops and compares.
// Optional drop-counter checks are compiled when PERIPH_SHELL_STATS_EN is defined.
module tb_periph_shell;
  import lycan_globals::*;

  localparam int PKT_W  = 32;
  localparam int ADDR_W = 3;
  localparam int PAY_W  = PKT_W - ADDR_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PAY_W-1:0] core_tx_data;
  logic             core_tx_empty;
  logic             core_tx_rden;
  logic [PAY_W-1:0] core_rx_data;
  logic             core_rx_wren;
  logic             core_rx_full;
  logic             ready;
`ifdef PERIPH_SHELL_STATS_EN
  logic [15:0]      tx_drop_cnt, rx_drop_cnt;
`endif

  always #5 clk = ~clk;

  periph_shell_if #(.PKT_W(PKT_W)) usb ();

  periph_shell #(
    .PKT_W        (PKT_W),
    .ADDR_W       (ADDR_W),
    .ADDRESS      (3'd2),
    .BCAST_EN     (1'b1),
    .TX_DEPTH     (16),
    .RX_DEPTH     (16),
    .RX_AFULL     (12),
    .READY_CYCLES (63)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .usb           (usb),
    .core_tx_data  (core_tx_data),
    .core_tx_empty (core_tx_empty),
    .core_tx_rden  (core_tx_rden),
    .core_rx_data  (core_rx_data),
    .core_rx_wren  (core_rx_wren),
    .core_rx_full  (core_rx_full),
    .ready         (ready)
`ifdef PERIPH_SHELL_STATS_EN
    ,
    .tx_drop_cnt   (tx_drop_cnt),
    .rx_drop_cnt   (rx_drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int tx_pops = 0;
  int rx_pops = 0;
  logic [PAY_W-1:0] txq [$];
  logic [PKT_W-1:0] rxq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared against the head of the matching queue.
  always @(negedge clk) begin
    if (rst_n && core_tx_rden && !core_tx_empty) begin
      tx_pops++;
      if (txq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL core_tx_unexpected: got %0h, expected no data", core_tx_data);
      end else begin
        check("core_tx_data", 32'(core_tx_data), 32'(txq.pop_front()));
      end
    end
    if (rst_n && usb.rx_read && !usb.rx_empty) begin
      rx_pops++;
      if (rxq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h, expected no data", usb.rx_data);
      end else begin
        check("rx_data", usb.rx_data, rxq.pop_front());
      end
    end
  end

  task automatic send_tx(input logic [PKT_W-1:0] d);
    usb.tx_data  = d;
    usb.tx_valid = 1'b1;
    @(posedge clk); #1;
    usb.tx_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [PAY_W-1:0] d);
    core_rx_data = d;
    core_rx_wren = 1'b1;
    @(posedge clk); #1;
    core_rx_wren = 1'b0;
  endtask

  task automatic drain_tx();
    int n = 0;
    while (!core_tx_empty && n < 40) begin
      core_tx_rden = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    core_tx_rden = 1'b0;
  endtask

  task automatic drain_rx();
    int n = 0;
    while (!usb.rx_empty && n < 40) begin
      usb.rx_read = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    usb.rx_read = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, 63);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int bad;
    usb.tx_data  = '0;
    usb.tx_valid = 1'b0;
    usb.rx_read  = 1'b0;
    core_tx_rden = 1'b0;
    core_rx_data = '0;
    core_rx_wren = 1'b0;

    // Reset values
    #13;
    check("rst_ready", ready, 0);
    check("rst_tx_full", usb.tx_full, 1);
    check("rst_rx_empty", usb.rx_empty, 1);
    check("rst_rx_almost_full", usb.rx_almost_full, 0);
    check("rst_rx_full", usb.rx_full, 0);
    check("rst_core_tx_empty", core_tx_empty, 1);
    check("rst_core_rx_full", core_rx_full, 1);
    check("rst_rx_data", usb.rx_data, 0);
    check("rst_core_tx_data", 32'(core_tx_data), 0);

    // 1: quiet period with the core writing every cycle
    #10;
    rst_n = 1'b1;
    core_rx_data = 29'h1234;
    core_rx_wren = 1'b1;
    n = 0;
    bad = 0;
    while (!ready && n < 200) begin
      if (!usb.rx_empty || !core_rx_full || !usb.tx_full) bad++;
      @(posedge clk); #1;
      n++;
    end
    core_rx_wren = 1'b0;
    check("ready_latency", n, 63);
    check("quiet_blocked", bad, 0);
    check("quiet_rx_empty", usb.rx_empty, 1);
    check("ready_core_rx_full", core_rx_full, 0);
`ifdef PERIPH_SHELL_STATS_EN
    check("quiet_rx_drops", 32'(rx_drop_cnt), 63);
`endif

    // 2: address filter and broadcast
    txq.push_back(29'h0000ABC);
    txq.push_back(29'h0000055);
    send_tx(32'h4000_0ABC);
    send_tx(32'h6000_0001);
    send_tx(32'hE000_0055);
    tx_pops = 0;
    drain_tx();
    check("filter_pops", tx_pops, 2);
    check("filter_queue_left", txq.size(), 0);

    // 3: overflow the TX FIFO
    for (int i = 0; i < 17; i++) begin
      if (i < 16) txq.push_back(PAY_W'(32'h100 + i));
      send_tx(32'h4000_0100 + i);
      if (i == 14) check("tx_full_at_15", usb.tx_full, 0);
      if (i == 15) check("tx_full_at_16", usb.tx_full, 1);
    end
`ifdef PERIPH_SHELL_STATS_EN
    check("tx_drop_after_17", 32'(tx_drop_cnt), 1);
`endif
    tx_pops = 0;
    drain_tx();
    check("overflow_pops", tx_pops, 16);
    check("overflow_tx_full_clear", usb.tx_full, 0);

    // 4: RX almost-full threshold and address tagging
    for (int i = 0; i < 12; i++) begin
      rxq.push_back({3'd2, PAY_W'(32'h200 + i)});
      send_rx(PAY_W'(32'h200 + i));
      if (i == 10) check("rx_afull_at_11", usb.rx_almost_full, 0);
    end
    check("rx_afull_at_12", usb.rx_almost_full, 1);
    check("rx_full_at_12", usb.rx_full, 0);
    check("rx_head_tagged", usb.rx_data, 32'h4000_0200);
    rx_pops = 0;
    drain_rx();
    check("rx_pops", rx_pops, 12);
    check("rx_afull_drained", usb.rx_almost_full, 0);

    // 5a: simultaneous read and write with 5 queued
    for (int i = 0; i < 5; i++) begin
      txq.push_back(PAY_W'(32'h300 + i));
      send_tx(32'h4000_0300 + i);
    end
    tx_pops = 0;
    txq.push_back(29'h0000555);
    usb.tx_data  = 32'h4000_0555;
    usb.tx_valid = 1'b1;
    core_tx_rden = 1'b1;
    @(posedge clk); #1;
    usb.tx_valid = 1'b0;
    core_tx_rden = 1'b0;
    drain_tx();
    check("rw5_total_pops", tx_pops, 6);

    // 5b: same stimulus with the FIFO full
    for (int i = 0; i < 16; i++) begin
      txq.push_back(PAY_W'(32'h400 + i));
      send_tx(32'h4000_0400 + i);
    end
    check("rw_full_before", usb.tx_full, 1);
    tx_pops = 0;
    usb.tx_data  = 32'h4000_0777;
    usb.tx_valid = 1'b1;
    core_tx_rden = 1'b1;
    @(posedge clk); #1;
    usb.tx_valid = 1'b0;
    core_tx_rden = 1'b0;
    check("rw_full_after", usb.tx_full, 0);
    drain_tx();
    check("rw_full_total_pops", tx_pops, 16);
`ifdef PERIPH_SHELL_STATS_EN
    check("tx_drop_rw_full", 32'(tx_drop_cnt), 2);
`endif

    // 6: reset mid-operation with both FIFOs half full
    for (int i = 0; i < 8; i++) begin
      send_tx(32'h4000_0500 + i);
      send_rx(PAY_W'(32'h600 + i));
    end
    check("half_core_tx_empty", core_tx_empty, 0);
    check("half_rx_empty", usb.rx_empty, 0);
    rst_n = 1'b0;
    txq.delete();
    rxq.delete();
    #1;
    check("mid_rst_ready", ready, 0);
    check("mid_rst_tx_full", usb.tx_full, 1);
    check("mid_rst_rx_empty", usb.rx_empty, 1);
    check("mid_rst_core_tx_empty", core_tx_empty, 1);
    check("mid_rst_core_rx_full", core_rx_full, 1);
    check("mid_rst_rx_data", usb.rx_data, 0);
    check("mid_rst_core_tx_data", 32'(core_tx_data), 0);
`ifdef PERIPH_SHELL_STATS_EN
    check("mid_rst_tx_drop", 32'(tx_drop_cnt), 0);
`endif
    @(posedge clk); #3;
    rst_n = 1'b1;
    wait_ready("ready_after_rerst");
    check("rerst_core_tx_empty", core_tx_empty, 1);
    check("rerst_rx_empty", usb.rx_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
